// File: rtl/uart_bridge_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the UART register bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h21;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/uart_reg_bridge.sv
// Parses W/R commands popped from the UART RX FIFO, runs one register-bus access
// and pushes a single response byte into the UART TX FIFO.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int BYTE_TIMEOUT = 1000000,
  parameter int BUS_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_ready,
  input  logic [7:0]        rx_byte,
  output logic              rx_read,
  input  logic              tx_fifo_full,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              err
);

  localparam int BYTE_CW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam int BUS_CW  = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [BYTE_CW-1:0] BYTE_MAX = BYTE_CW'(BYTE_TIMEOUT - 1);
  localparam logic [BUS_CW-1:0]  BUS_MAX  = BUS_CW'(BUS_TIMEOUT - 1);

  state_t              state, state_d;
  logic                is_wr;
  logic [7:0]          a_hi;
  logic [7:0]          resp, resp_d;
  logic [BYTE_CW-1:0]  byte_cnt;
  logic [BUS_CW-1:0]   bus_cnt;
  logic                in_cmd, capture, byte_tmo, bus_tmo, bad_op;
  logic [15:0]         addr_full;

  // rx_byte is stale while rx_read is high, so captures are spaced two cycles apart.
  assign in_cmd    = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
  assign capture   = ((state == IDLE) || in_cmd) && rx_ready && !rx_read;
  assign byte_tmo  = in_cmd && !capture && (byte_cnt == BYTE_MAX);
  assign bus_tmo   = (state == BUS) && !bus_ack && (bus_cnt == BUS_MAX);
  assign addr_full = {a_hi, rx_byte};

  assign busy     = (state != IDLE);
  assign bus_we   = (state == BUS) && is_wr;
  assign bus_re   = (state == BUS) && !is_wr;
  assign tx_start = (state == RESP) && !tx_fifo_full;
  assign tx_data  = tx_start ? resp : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    resp_d  = resp;
    bad_op  = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          if ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) begin
            state_d = ADDR_HI;
          end else begin
            state_d = RESP;
            resp_d  = RSP_BAD;
            bad_op  = 1'b1;
          end
        end
      end
      ADDR_HI: begin
        if (capture)       state_d = ADDR_LO;
        else if (byte_tmo) state_d = IDLE;
      end
      ADDR_LO: begin
        if (capture)       state_d = is_wr ? DATA : BUS;
        else if (byte_tmo) state_d = IDLE;
      end
      DATA: begin
        if (capture)       state_d = BUS;
        else if (byte_tmo) state_d = IDLE;
      end
      BUS: begin
        if (bus_ack) begin
          state_d = RESP;
          resp_d  = is_wr ? RSP_OK : bus_rdata;
        end else if (bus_tmo) begin
          state_d = RESP;
          resp_d  = RSP_TMO;
        end
      end
      RESP: begin
        if (!tx_fifo_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_read   <= 1'b0;
      err       <= 1'b0;
      is_wr     <= 1'b0;
      a_hi      <= 8'h00;
      resp      <= 8'h00;
      bus_addr  <= '0;
      bus_wdata <= 8'h00;
      byte_cnt  <= '0;
      bus_cnt   <= '0;
    end else begin
      rx_read <= capture;
      err     <= bad_op || byte_tmo || bus_tmo;
      resp    <= resp_d;
      if (capture) begin
        case (state)
          IDLE:    is_wr     <= (rx_byte == CMD_WR);
          ADDR_HI: a_hi      <= rx_byte;
          ADDR_LO: bus_addr  <= addr_full[ADDR_W-1:0];
          DATA:    bus_wdata <= rx_byte;
          default: ;
        endcase
      end
      // Both counters saturate at their limit instead of wrapping.
      if (!in_cmd || capture)       byte_cnt <= '0;
      else if (byte_cnt != BYTE_MAX) byte_cnt <= byte_cnt + BYTE_CW'(1);
      if (state != BUS)             bus_cnt <= '0;
      else if (bus_cnt != BUS_MAX)  bus_cnt <= bus_cnt + BUS_CW'(1);
    end
  end

endmodule
